traffic_light_fsm: RTL and testbench

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

---
 rtl/traffic_light_fsm.sv | 152 +++++++++++++++
 tb/tb_traffic_light_fsm.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm
//   Main/side street intersection controller with a pedestrian walk phase.
//   The controller sequences seven states and tells an external countdown
//   Timer how long to dwell in each one. On every state entry it loads
//   Value and pulses start_timer for exactly one cycle. The Timer answers
//   with expired. Lamps are decoded from the state register only (Moore).
//
// Parameters
//   T_BASE  base green duration, seconds (0 is treated as 1)
//   T_EXT   extension / walk duration, seconds (0 is treated as 1)
//   T_YEL   yellow duration, seconds (0 is treated as 1)
//
// Ports
//   clk           in   system clock, rising edge
//   Reset_Sync    in   asynchronous active-high reset
//   expired       in   Timer countdown-complete flag
//   Sensor        in   side-street vehicle present (level)
//   Walk_Request  in   pedestrian button
//   Value         out  [3:0] duration loaded into the Timer
//   start_timer   out  Timer load strobe, one cycle per state entry
//   main_light    out  [2:0] main-street lamps {R,Y,G}, one-hot
//   side_light    out  [2:0] side-street lamps {R,Y,G}, one-hot
//   walk_light    out  pedestrian walk lamp
module traffic_light_fsm #(
  parameter logic [3:0] T_BASE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2
) (
  input  logic       clk,
  input  logic       Reset_Sync,
  input  logic       expired,
  input  logic       Sensor,
  input  logic       Walk_Request,
  output logic [3:0] Value,
  output logic       start_timer,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light
);

  typedef enum logic [2:0] {
    MG1    = 3'd0,
    MG2    = 3'd1,
    MY     = 3'd2,
    WALK   = 3'd3,
    SG     = 3'd4,
    SG_EXT = 3'd5,
    SY     = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // A zero load would leave the Timer expiring immediately or never,
  // so every duration is forced to at least one second.
  function automatic logic [3:0] clamp_dur(input logic [3:0] d);
    return (d == 4'd0) ? 4'd1 : d;
  endfunction

  // Dwell time of the state being entered. MG2 is the only entry whose
  // duration depends on Sensor, sampled on that same edge.
  function automatic logic [3:0] entry_dur(input state_t s, input logic sens);
    logic [3:0] d;
    case (s)
      MG1:     d = T_BASE;
      MG2:     d = sens ? T_EXT : T_BASE;
      MY:      d = T_YEL;
      WALK:    d = T_EXT;
      SG:      d = T_BASE;
      SG_EXT:  d = T_EXT;
      SY:      d = T_YEL;
      default: d = T_BASE;
    endcase
    return clamp_dur(d);
  endfunction

  state_t state;
  state_t state_nxt;
  logic   walk_pending;
  logic   expiry_qual;

  // An expired seen in the load cycle belongs to the previous countdown
  // and must not advance the new state.
  assign expiry_qual = expired && !start_timer;

  // State, Timer load and walk latch
  always_ff @(posedge clk or posedge Reset_Sync) begin
    if (Reset_Sync) begin
      state        <= MG1;
      Value        <= clamp_dur(T_BASE);
      start_timer  <= 1'b1;
      walk_pending <= 1'b0;
    end else begin
      start_timer <= 1'b0;
      if (expiry_qual) begin
        state       <= state_nxt;
        Value       <= entry_dur(state_nxt, Sensor);
        start_timer <= 1'b1;
      end
      // Entering WALK serves the request; presses on that edge or while
      // walking are dropped so they do not trigger a second walk phase.
      if (expiry_qual && state_nxt == WALK) begin
        walk_pending <= 1'b0;
      end else if (Walk_Request && state != WALK) begin
        walk_pending <= 1'b1;
      end
    end
  end

  // Next state and lamp decode
  always_comb begin
    state_nxt  = state;
    main_light = LAMP_R;
    side_light = LAMP_R;
    walk_light = 1'b0;
    case (state)
      MG1: begin
        state_nxt  = MG2;
        main_light = LAMP_G;
      end
      MG2: begin
        state_nxt  = MY;
        main_light = LAMP_G;
      end
      MY: begin
        state_nxt  = walk_pending ? WALK : SG;
        main_light = LAMP_Y;
      end
      WALK: begin
        state_nxt  = SG;
        walk_light = 1'b1;
      end
      SG: begin
        state_nxt  = Sensor ? SG_EXT : SY;
        side_light = LAMP_G;
      end
      SG_EXT: begin
        state_nxt  = SY;
        side_light = LAMP_G;
      end
      SY: begin
        state_nxt  = MG1;
        side_light = LAMP_Y;
      end
      default: begin
        state_nxt = MG1;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
module tb_traffic_light_fsm;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       Reset_Sync;
  logic       expired;
  logic       Sensor;
  logic       Walk_Request;
  logic [3:0] Value;
  logic       start_timer;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_light;

  logic [3:0] z_value;
  logic       z_start;
  logic [2:0] z_main;
  logic [2:0] z_side;
  logic       z_walk;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  traffic_light_fsm dut (
    .clk          (clk),
    .Reset_Sync   (Reset_Sync),
    .expired      (expired),
    .Sensor       (Sensor),
    .Walk_Request (Walk_Request),
    .Value        (Value),
    .start_timer  (start_timer),
    .main_light   (main_light),
    .side_light   (side_light),
    .walk_light   (walk_light)
  );

  // All-zero parameters: every load must come out as 1.
  traffic_light_fsm #(.T_BASE(4'd0), .T_EXT(4'd0), .T_YEL(4'd0)) dut_zero (
    .clk          (clk),
    .Reset_Sync   (Reset_Sync),
    .expired      (expired),
    .Sensor       (Sensor),
    .Walk_Request (Walk_Request),
    .Value        (z_value),
    .start_timer  (z_start),
    .main_light   (z_main),
    .side_light   (z_side),
    .walk_light   (z_walk)
  );

  typedef struct {
    logic       exp;
    logic       sens;
    logic       wr;
    logic [2:0] main;
    logic [2:0] side;
    logic       walk;
    logic       start;
    logic [3:0] value;
  } vec_t;

  vec_t vec [40];

  task automatic check_out(input string name, input logic [2:0] emain,
                           input logic [2:0] eside, input logic ewalk,
                           input logic estart, input logic [3:0] evalue);
    logic [11:0] act;
    logic [11:0] req;
    act = {main_light, side_light, walk_light, start_timer, Value};
    req = {emain, eside, ewalk, estart, evalue};
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: main/side/walk/start/value got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                  name, main_light, side_light, walk_light, start_timer, Value,
                  emain, eside, ewalk, estart, evalue);
  endtask

  task automatic check_zero(input string name);
    n_total++;
    if (z_value === 4'd1) n_pass++;
    else $display("FAIL %s: clamped Value got %0d expected 1", name, z_value);
  endtask

  // Inputs are applied mid-cycle, outputs sampled 1 time unit after the edge.
  task automatic step(input string name, input logic e, input logic s, input logic w,
                      input logic [2:0] emain, input logic [2:0] eside, input logic ewalk,
                      input logic estart, input logic [3:0] evalue);
    expired      = e;
    Sensor       = s;
    Walk_Request = w;
    @(posedge clk);
    #1;
    check_out(name, emain, eside, ewalk, estart, evalue);
  endtask

  initial begin
    //         exp  sens wr    main side walk start value
    // Sensor=0, no walk; v2 holds expired across the load cycle
    vec[0]  = '{1'b0, 1'b0, 1'b0, G, R, 1'b0, 1'b0, 4'd6};
    vec[1]  = '{1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b1, 4'd6};
    vec[2]  = '{1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b0, 4'd6};
    vec[3]  = '{1'b1, 1'b0, 1'b0, Y, R, 1'b0, 1'b1, 4'd2};
    vec[4]  = '{1'b0, 1'b0, 1'b0, Y, R, 1'b0, 1'b0, 4'd2};
    vec[5]  = '{1'b1, 1'b0, 1'b0, R, G, 1'b0, 1'b1, 4'd6};
    vec[6]  = '{1'b0, 1'b0, 1'b0, R, G, 1'b0, 1'b0, 4'd6};
    vec[7]  = '{1'b1, 1'b0, 1'b0, R, Y, 1'b0, 1'b1, 4'd2};
    vec[8]  = '{1'b0, 1'b0, 1'b0, R, Y, 1'b0, 1'b0, 4'd2};
    vec[9]  = '{1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b1, 4'd6};
    // Sensor extensions
    vec[10] = '{1'b0, 1'b1, 1'b0, G, R, 1'b0, 1'b0, 4'd6};
    vec[11] = '{1'b1, 1'b1, 1'b0, G, R, 1'b0, 1'b1, 4'd3};
    vec[12] = '{1'b0, 1'b0, 1'b0, G, R, 1'b0, 1'b0, 4'd3};
    vec[13] = '{1'b1, 1'b0, 1'b0, Y, R, 1'b0, 1'b1, 4'd2};
    vec[14] = '{1'b0, 1'b0, 1'b0, Y, R, 1'b0, 1'b0, 4'd2};
    vec[15] = '{1'b1, 1'b0, 1'b0, R, G, 1'b0, 1'b1, 4'd6};
    vec[16] = '{1'b0, 1'b1, 1'b0, R, G, 1'b0, 1'b0, 4'd6};
    vec[17] = '{1'b1, 1'b1, 1'b0, R, G, 1'b0, 1'b1, 4'd3};
    vec[18] = '{1'b0, 1'b0, 1'b0, R, G, 1'b0, 1'b0, 4'd3};
    vec[19] = '{1'b1, 1'b1, 1'b0, R, Y, 1'b0, 1'b1, 4'd2};
    vec[20] = '{1'b0, 1'b0, 1'b0, R, Y, 1'b0, 1'b0, 4'd2};
    vec[21] = '{1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b1, 4'd6};
    // One-cycle walk request in MG1, a discarded press during WALK
    vec[22] = '{1'b0, 1'b0, 1'b1, G, R, 1'b0, 1'b0, 4'd6};
    vec[23] = '{1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b1, 4'd6};
    vec[24] = '{1'b0, 1'b0, 1'b0, G, R, 1'b0, 1'b0, 4'd6};
    vec[25] = '{1'b1, 1'b0, 1'b0, Y, R, 1'b0, 1'b1, 4'd2};
    vec[26] = '{1'b0, 1'b0, 1'b0, Y, R, 1'b0, 1'b0, 4'd2};
    vec[27] = '{1'b1, 1'b0, 1'b0, R, R, 1'b1, 1'b1, 4'd3};
    vec[28] = '{1'b0, 1'b0, 1'b1, R, R, 1'b1, 1'b0, 4'd3};
    vec[29] = '{1'b1, 1'b0, 1'b0, R, G, 1'b0, 1'b1, 4'd6};
    vec[30] = '{1'b0, 1'b0, 1'b0, R, G, 1'b0, 1'b0, 4'd6};
    vec[31] = '{1'b1, 1'b0, 1'b0, R, Y, 1'b0, 1'b1, 4'd2};
    vec[32] = '{1'b0, 1'b0, 1'b0, R, Y, 1'b0, 1'b0, 4'd2};
    vec[33] = '{1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b1, 4'd6};
    vec[34] = '{1'b0, 1'b0, 1'b0, G, R, 1'b0, 1'b0, 4'd6};
    vec[35] = '{1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b1, 4'd6};
    vec[36] = '{1'b0, 1'b0, 1'b0, G, R, 1'b0, 1'b0, 4'd6};
    vec[37] = '{1'b1, 1'b0, 1'b0, Y, R, 1'b0, 1'b1, 4'd2};
    vec[38] = '{1'b0, 1'b0, 1'b0, Y, R, 1'b0, 1'b0, 4'd2};
    vec[39] = '{1'b1, 1'b0, 1'b0, R, G, 1'b0, 1'b1, 4'd6};

    Reset_Sync   = 1'b1;
    expired      = 1'b0;
    Sensor       = 1'b0;
    Walk_Request = 1'b0;

    #12;
    check_out("reset_hold", G, R, 1'b0, 1'b1, 4'd6);
    check_zero("reset_clamp");

    @(posedge clk);
    #3 Reset_Sync = 1'b0;
    #1;
    check_out("release", G, R, 1'b0, 1'b1, 4'd6);

    for (int i = 0; i < 40; i++) begin
      expired      = vec[i].exp;
      Sensor       = vec[i].sens;
      Walk_Request = vec[i].wr;
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vec[i].main, vec[i].side, vec[i].walk,
                vec[i].start, vec[i].value);
      check_zero($sformatf("clamp%0d", i));
    end

    // Now in SG with a fresh load; queue a walk, then reset mid-dwell.
    step("sg_walkreq", 1'b0, 1'b0, 1'b1, R, G, 1'b0, 1'b0, 4'd6);
    Walk_Request = 1'b0;
    #2 Reset_Sync = 1'b1;
    #1;
    check_out("async_reset", G, R, 1'b0, 1'b1, 4'd6);
    @(posedge clk);
    #3 Reset_Sync = 1'b0;
    #1;
    check_out("release2", G, R, 1'b0, 1'b1, 4'd6);
    step("r2_mg1",  1'b0, 1'b0, 1'b0, G, R, 1'b0, 1'b0, 4'd6);
    step("r2_mg2",  1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b1, 4'd6);
    step("r2_mg2b", 1'b0, 1'b0, 1'b0, G, R, 1'b0, 1'b0, 4'd6);
    step("r2_my",   1'b1, 1'b0, 1'b0, Y, R, 1'b0, 1'b1, 4'd2);
    step("r2_myb",  1'b0, 1'b0, 1'b0, Y, R, 1'b0, 1'b0, 4'd2);
    step("r2_sg",   1'b1, 1'b0, 1'b0, R, G, 1'b0, 1'b1, 4'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
